fir_channel_scheduler: RTL
==========================

// Module: fir_channel_scheduler
// PURPOSE
//   Time-shares one FIR engine among NUM_CH sample requesters. Round-robin arbitration; one sample in flight.
//   Each result is tagged with the requester's channel index. Sits between the channel sources and the engine.
//   Any response from the engine is returned with the same tag.
//   A watchdog recovers from a stalled engine by pulsing an engine reset.
// PARAMETERS
//   DATA_WIDTH  24    sample/result width, signed two's complement, passed through unmodified
//   NUM_CH      4     number of requesters, 2..16; CH_W = max(1,$clog2(NUM_CH)) is a localparam
//   TIMEOUT     1024  cycles allowed in SEND or WAIT before the watchdog fires, >= 2
// PORTS
//   i_clk            in   1              clock, all logic on rising edge
//   i_rst            in   1              synchronous, active-high reset
//   iv_ch_valid      in   NUM_CH         per-channel sample valid
//   iv_ch_data       in   NUM_CH*DW      channel k sample at [k*DW +: DW]
//   ov_ch_ready      out  NUM_CH         one-hot 1-cycle pulse: channel k's sample accepted
//   ov_eng_din       out  DW             sample to engine
//   o_eng_din_valid  out  1              sample valid to engine
//   i_eng_din_ack    in   1              engine consumed sample (pulse)
//   iv_eng_dout      in   DW             engine result
//   i_eng_dout_valid in   1              engine result valid
//   o_eng_dout_ack   out  1              1-cycle pulse: result captured (engine's ready input)
//   o_eng_rst        out  1              1-cycle engine reset pulse from watchdog
//   ov_dout          out  DW             tagged result
//   ov_dout_ch       out  CH_W           channel index of ov_dout
//   o_dout_valid     out  1              result valid, held until i_dout_ready
//   i_dout_ready     in   1              downstream accepts result
//   o_busy           out  1              1 whenever state != IDLE
//   o_timeout        out  1              sticky; set by watchdog, cleared only by i_rst
// BEHAVIOUR
//   States: IDLE, GRANT, SEND, WAIT, OUT. All outputs are registered.
//   Reset: state=IDLE; all outputs 0; last_grant=NUM_CH-1, so channel 0 has top priority first.
//   IDLE: if any iv_ch_valid, pick the first set bit scanning from last_grant+1 with wrap.
//     Latch its data and index; last_grant<=index; go GRANT. Otherwise stay.
//   GRANT (1 cycle): ov_ch_ready[index]=1, all other bits 0. Then go SEND.
//     A source holds valid/data until it sees ready; valid is sampled only in IDLE.
//   SEND: o_eng_din_valid=1, ov_eng_din=latched sample. Go WAIT on the cycle i_eng_din_ack=1.
//     o_eng_din_valid is deasserted from the next cycle.
//   WAIT: on i_eng_dout_valid=1, capture iv_eng_dout into ov_dout and set ov_dout_ch=index.
//     Go OUT; o_eng_dout_ack=1 for exactly the first cycle of OUT.
//     An i_eng_dout_valid already high on WAIT entry is captured in that cycle.
//   OUT: o_dout_valid=1 and holds; ov_dout/ov_dout_ch stable.
//     On i_dout_ready=1, go IDLE; o_dout_valid=0 next cycle. No watchdog in OUT.
//   Latency: sample accepted in IDLE at cycle t -> ready pulse at t+1 -> engine valid from t+2.
//     Result at WAIT cycle r -> o_dout_valid from r+1.
//   Minimum throughput: one sample per 5 cycles plus engine latency. Back-to-back grants rotate fairly.
//   Watchdog: counter clears on entry to SEND and to WAIT and increments each cycle there.
//     When the counter reaches TIMEOUT-1 without the exit event:
//       o_timeout<=1, o_eng_rst pulses one cycle, the sample is dropped, go IDLE.
//     No output is produced and no second ready pulse is issued.
//   Acks arriving outside SEND/WAIT (i_eng_din_ack, i_eng_dout_valid) are ignored.
//   i_rst mid-operation: immediate return to IDLE. An in-flight sample is discarded.
//     Pointer is reset and o_timeout cleared.
// TESTING
//   1. Single: ch2 valid, data 0x000123, engine echoes after 5 cycles.
//      -> ov_ch_ready=4'b0100 once; ov_dout=0x000123, ov_dout_ch=2.
//   2. Round-robin: all 4 channels valid continuously, 8 samples.
//      -> grant order 0,1,2,3,0,1,2,3; tags match data.
//   3. Backpressure: i_dout_ready low 20 cycles.
//      -> o_dout_valid, ov_dout, ov_dout_ch stable; no new grant until accepted.
//   4. Stall: engine never acks, TIMEOUT=16.
//      -> after 16 SEND cycles o_eng_rst pulses once, o_timeout=1, next request still served.
//   5. Reset in WAIT: assert i_rst 1 cycle.
//      -> all outputs 0, next grant goes to ch0 even if last_grant was ch1.
//   6. Spurious engine valid in IDLE/OUT -> ignored; exactly one o_eng_dout_ack per accepted sample.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR engine among NUM_CH requesters.
// Results come back tagged with the channel index; a watchdog resets a stalled engine.
module fir_channel_scheduler #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_CH     = 4,
    parameter int TIMEOUT    = 1024,
    localparam int CH_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH-1:0]            iv_ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] iv_ch_data,
    output logic [NUM_CH-1:0]            ov_ch_ready,
    output logic [DATA_WIDTH-1:0]        ov_eng_din,
    output logic                         o_eng_din_valid,
    input  logic                         i_eng_din_ack,
    input  logic [DATA_WIDTH-1:0]        iv_eng_dout,
    input  logic                         i_eng_dout_valid,
    output logic                         o_eng_dout_ack,
    output logic                         o_eng_rst,
    output logic [DATA_WIDTH-1:0]        ov_dout,
    output logic [CH_W-1:0]              ov_dout_ch,
    output logic                         o_dout_valid,
    input  logic                         i_dout_ready,
    output logic                         o_busy,
    output logic                         o_timeout
);

    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEND,
        WAIT,
        OUT
    } state_t;

    state_t                state, state_n;
    logic [CH_W-1:0]       idx, idx_n;
    logic [CH_W-1:0]       last_grant, last_grant_n;
    logic [WD_W-1:0]       wd_cnt, wd_cnt_n;
    logic                  wd_hit;
    logic [DATA_WIDTH-1:0] din_n, dout_n;
    logic [CH_W-1:0]       dout_ch_n;
    logic                  timeout_n, eng_rst_n, dout_ack_n;
    logic                  pick_found;
    logic [CH_W-1:0]       pick;

    function automatic logic [CH_W-1:0] wrap(input int v);
        return CH_W'(v % NUM_CH);
    endfunction

    // Scan downwards so the channel right after last_grant wins.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (iv_ch_valid[wrap(int'(last_grant) + i)]) begin
                pick_found = 1'b1;
                pick       = wrap(int'(last_grant) + i);
            end
        end
    end

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        last_grant_n = last_grant;
        wd_cnt_n     = wd_cnt;
        din_n        = ov_eng_din;
        dout_n       = ov_dout;
        dout_ch_n    = ov_dout_ch;
        timeout_n    = o_timeout;
        eng_rst_n    = 1'b0;
        dout_ack_n   = 1'b0;
        wd_hit       = (wd_cnt == WD_W'(TIMEOUT - 1));
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    idx_n        = pick;
                    last_grant_n = pick;
                    din_n        = iv_ch_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    state_n      = GRANT;
                end
            end
            GRANT: state_n = SEND;
            SEND: begin
                if (i_eng_din_ack) begin
                    state_n = WAIT;
                end else if (wd_hit) begin
                    state_n   = IDLE;
                    eng_rst_n = 1'b1;
                    timeout_n = 1'b1;
                end
            end
            WAIT: begin
                if (i_eng_dout_valid) begin
                    dout_n     = iv_eng_dout;
                    dout_ch_n  = idx;
                    dout_ack_n = 1'b1;
                    state_n    = OUT;
                end else if (wd_hit) begin
                    state_n   = IDLE;
                    eng_rst_n = 1'b1;
                    timeout_n = 1'b1;
                end
            end
            OUT: begin
                if (i_dout_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n != state) begin
            wd_cnt_n = '0;
        end else if (state == SEND || state == WAIT) begin
            wd_cnt_n = wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            idx             <= '0;
            last_grant      <= CH_W'(NUM_CH - 1);
            wd_cnt          <= '0;
            ov_ch_ready     <= '0;
            ov_eng_din      <= '0;
            o_eng_din_valid <= 1'b0;
            o_eng_dout_ack  <= 1'b0;
            o_eng_rst       <= 1'b0;
            ov_dout         <= '0;
            ov_dout_ch      <= '0;
            o_dout_valid    <= 1'b0;
            o_busy          <= 1'b0;
            o_timeout       <= 1'b0;
        end else begin
            state           <= state_n;
            idx             <= idx_n;
            last_grant      <= last_grant_n;
            wd_cnt          <= wd_cnt_n;
            ov_ch_ready     <= (state_n == GRANT) ? (NUM_CH'(1) << idx_n) : '0;
            ov_eng_din      <= din_n;
            o_eng_din_valid <= (state_n == SEND);
            o_eng_dout_ack  <= dout_ack_n;
            o_eng_rst       <= eng_rst_n;
            ov_dout         <= dout_n;
            ov_dout_ch      <= dout_ch_n;
            o_dout_valid    <= (state_n == OUT);
            o_busy          <= (state_n != IDLE);
            o_timeout       <= timeout_n;
        end
    end

endmodule
